// File: rtl/secuenciador_registros.sv
// secuenciador_registros: sequences RTC bus transfers for the ten-entry
// clock/date/timer register bank. A refresh reads every register not under
// edit and strobes cs per register; a write-back writes one edited group.
module secuenciador_registros #(
    parameter int unsigned T_MAX = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_rd,
    input  logic       req_wr,
    input  logic [1:0] wr_grupo,
    input  logic       edit_en,
    input  logic [1:0] edit_grupo,
    input  logic       bus_done,
    output logic       bus_req,
    output logic       bus_we,
    output logic [7:0] bus_addr,
    output logic [9:0] cs,
    output logic [9:0] hold,
    output logic       busy,
    output logic       wr_ack,
    output logic       err
);

    // Counter only has to reach T_MAX-1: the timeout fires on the last WAIT cycle.
    localparam int unsigned CW = (T_MAX < 2) ? 1 : $clog2(T_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(T_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_LATCH,
        S_NEXT,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [3:0]      idx_q;
    logic [3:0]      last_q;
    logic            we_seq_q;
    logic [CW-1:0]   cnt_q;
    logic            rd_pend_q;
    logic            wr_pend_q;
    logic [1:0]      wr_grp_q;
    logic            bus_req_q;
    logic            bus_we_q;
    logic [7:0]      bus_addr_q;
    logic [9:0]      cs_q;
    logic            busy_q;
    logic            wr_ack_q;
    logic            err_q;

    logic            rd_pend_d;
    logic            wr_pend_d;
    logic [1:0]      wr_grp_d;
    logic [3:0]      idx_inc;
    logic [9:0]      hold_c;

    function automatic logic [7:0] addr_of(input logic [3:0] i);
        case (i)
            4'd0:    addr_of = 8'h21;
            4'd1:    addr_of = 8'h22;
            4'd2:    addr_of = 8'h23;
            4'd3:    addr_of = 8'h24;
            4'd4:    addr_of = 8'h25;
            4'd5:    addr_of = 8'h26;
            4'd6:    addr_of = 8'h27;
            4'd7:    addr_of = 8'h41;
            4'd8:    addr_of = 8'h42;
            4'd9:    addr_of = 8'h43;
            default: addr_of = 8'h00;
        endcase
    endfunction

    function automatic logic [3:0] first_of(input logic [1:0] g);
        case (g)
            2'd0:    first_of = 4'd0;
            2'd1:    first_of = 4'd3;
            default: first_of = 4'd7;
        endcase
    endfunction

    function automatic logic [3:0] last_of(input logic [1:0] g);
        case (g)
            2'd0:    last_of = 4'd2;
            2'd1:    last_of = 4'd6;
            default: last_of = 4'd9;
        endcase
    endfunction

    // Per-register hold follows the edit inputs directly.
    always_comb begin
        hold_c = '0;
        if (edit_en) begin
            case (edit_grupo)
                2'd0:    hold_c[2:0] = '1;
                2'd1:    hold_c[6:3] = '1;
                2'd2:    hold_c[9:7] = '1;
                default: hold_c = '0;
            endcase
        end
    end

    // A request arriving this cycle is visible to IDLE immediately.
    assign rd_pend_d = rd_pend_q | start_rd;
    assign wr_pend_d = wr_pend_q | req_wr;
    assign wr_grp_d  = req_wr ? wr_grupo : wr_grp_q;
    assign idx_inc   = idx_q + 4'd1;

    // Sequencer FSM with registered bus/strobe outputs and pending flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            last_q     <= '0;
            we_seq_q   <= 1'b0;
            cnt_q      <= '0;
            rd_pend_q  <= 1'b0;
            wr_pend_q  <= 1'b0;
            wr_grp_q   <= '0;
            bus_req_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_addr_q <= '0;
            cs_q       <= '0;
            busy_q     <= 1'b0;
            wr_ack_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cs_q      <= '0;
            wr_ack_q  <= 1'b0;
            err_q     <= 1'b0;
            rd_pend_q <= rd_pend_d;
            wr_pend_q <= wr_pend_d;
            wr_grp_q  <= wr_grp_d;

            case (state_q)
                S_IDLE: begin
                    if (wr_pend_d && (wr_grp_d != 2'd3)) begin
                        wr_pend_q  <= 1'b0;
                        we_seq_q   <= 1'b1;
                        idx_q      <= first_of(wr_grp_d);
                        last_q     <= last_of(wr_grp_d);
                        bus_req_q  <= 1'b1;
                        bus_we_q   <= 1'b1;
                        bus_addr_q <= addr_of(first_of(wr_grp_d));
                        busy_q     <= 1'b1;
                        state_q    <= S_ISSUE;
                    end else begin
                        // An invalid-group write is dropped without touching the bus.
                        if (wr_pend_d) begin
                            wr_pend_q <= 1'b0;
                        end
                        if (rd_pend_d) begin
                            rd_pend_q <= 1'b0;
                            we_seq_q  <= 1'b0;
                            idx_q     <= 4'd0;
                            last_q    <= 4'd9;
                            busy_q    <= 1'b1;
                            if (hold_c[0]) begin
                                state_q <= S_NEXT;
                            end else begin
                                bus_req_q  <= 1'b1;
                                bus_we_q   <= 1'b0;
                                bus_addr_q <= addr_of(4'd0);
                                state_q    <= S_ISSUE;
                            end
                        end
                    end
                end

                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end

                S_WAIT: begin
                    if (bus_done) begin
                        bus_req_q  <= 1'b0;
                        bus_we_q   <= 1'b0;
                        bus_addr_q <= '0;
                        if (!we_seq_q) begin
                            cs_q    <= 10'd1 << idx_q;
                            state_q <= S_LATCH;
                        end else begin
                            state_q <= S_NEXT;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        bus_req_q  <= 1'b0;
                        bus_we_q   <= 1'b0;
                        bus_addr_q <= '0;
                        err_q      <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_LATCH: begin
                    state_q <= S_NEXT;
                end

                S_NEXT: begin
                    if (idx_q == last_q) begin
                        wr_ack_q <= we_seq_q;
                        state_q  <= S_DONE;
                    end else begin
                        idx_q <= idx_inc;
                        if (!we_seq_q && hold_c[idx_inc]) begin
                            state_q <= S_NEXT;
                        end else begin
                            bus_req_q  <= 1'b1;
                            bus_we_q   <= we_seq_q;
                            bus_addr_q <= addr_of(idx_inc);
                            state_q    <= S_ISSUE;
                        end
                    end
                end

                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus_req  = bus_req_q;
    assign bus_we   = bus_we_q;
    assign bus_addr = bus_addr_q;
    assign cs       = cs_q;
    assign hold     = hold_c;
    assign busy     = busy_q;
    assign wr_ack   = wr_ack_q;
    assign err      = err_q;

endmodule

// File: tb/tb_secuenciador_registros.sv
// Testbench for secuenciador_registros: directed and randomized sequences
// checked against a transaction-level reference of the register map.
module tb_secuenciador_registros;

    logic       clk = 1'b0;
    logic       reset, start_rd, req_wr, edit_en, bus_done;
    logic [1:0] wr_grupo, edit_grupo;
    logic       bus_req, bus_we, busy, wr_ack, err;
    logic [7:0] bus_addr;
    logic [9:0] cs, hold;

    always #5 clk = ~clk;

    secuenciador_registros #(.T_MAX(255)) dut (
        .clk(clk), .reset(reset), .start_rd(start_rd), .req_wr(req_wr),
        .wr_grupo(wr_grupo), .edit_en(edit_en), .edit_grupo(edit_grupo),
        .bus_done(bus_done), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .cs(cs), .hold(hold), .busy(busy),
        .wr_ack(wr_ack), .err(err)
    );

    logic [7:0] addr_tab [10] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25,
                                  8'h26, 8'h27, 8'h41, 8'h42, 8'h43};

    int n_pass = 0, n_total = 0;
    int cyc = 0, rise_cyc = 0, first_rise = 0, err_cyc = 0;
    int busy_rise_cyc = 0, busy_len = 0, n_busy_fall = 0, n_ack = 0, n_err = 0;
    int lat = 2;
    bit withhold = 1'b0;
    logic prev_req = 1'b0, prev_we = 1'b0, prev_busy = 1'b0;
    logic [7:0] prev_addr = '0;
    logic [8:0] obs_tx[$], exp_tx[$];
    int obs_cs[$], exp_cs[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic bit in_group(input int i, input logic [1:0] g);
        case (g)
            2'd0:    return i <= 2;
            2'd1:    return i >= 3 && i <= 6;
            2'd2:    return i >= 7;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [9:0] model_hold(input logic en, input logic [1:0] g);
        logic [9:0] h = '0;
        for (int i = 0; i < 10; i++) h[i] = en && in_group(i, g);
        return h;
    endfunction

    task automatic add_read(input logic [9:0] h);
        for (int i = 0; i < 10; i++)
            if (!h[i]) begin
                exp_tx.push_back({1'b0, addr_tab[i]});
                exp_cs.push_back(i);
            end
    endtask

    task automatic add_write(input logic [1:0] g);
        for (int i = 0; i < 10; i++)
            if (in_group(i, g)) exp_tx.push_back({1'b1, addr_tab[i]});
    endtask

    // Cycles busy stays high: per-index cost plus the DONE cycle.
    function automatic int len_read(input logic [9:0] h, input int l);
        int s = 1;
        for (int i = 0; i < 10; i++) s += h[i] ? 1 : 3 + l;
        return s;
    endfunction

    function automatic int len_write(input logic [1:0] g, input int l);
        int s = 1;
        for (int i = 0; i < 10; i++) if (in_group(i, g)) s += 2 + l;
        return s;
    endfunction

    task automatic clear_obs();
        obs_tx.delete(); obs_cs.delete(); exp_tx.delete(); exp_cs.delete();
        n_ack = 0; n_err = 0; n_busy_fall = 0;
    endtask

    // One clock: sample just after the edge, record events, drive the RTC responder.
    task automatic step();
        logic done_last;
        @(posedge clk);
        #1;
        cyc++;
        done_last = bus_done;
        chk("hold", hold, model_hold(edit_en, edit_grupo));
        chk("cs_onehot", 32'($onehot0(cs)), 1);
        if (cs != '0) begin
            chk("cs_we", bus_we, 0);
            chk("cs_after_done", done_last, 1);
            chk("cs_req_low", bus_req, 0);
            for (int i = 0; i < 10; i++) if (cs[i]) obs_cs.push_back(i);
        end
        if (bus_req && !prev_req) begin
            if (obs_tx.size() == 0) first_rise = cyc;
            obs_tx.push_back({bus_we, bus_addr});
            rise_cyc = cyc;
        end else if (bus_req) begin
            chk("addr_stable", {bus_we, bus_addr}, {prev_we, prev_addr});
        end
        if (busy && !prev_busy) busy_rise_cyc = cyc;
        if (!busy && prev_busy) begin
            busy_len = cyc - busy_rise_cyc;
            n_busy_fall++;
        end
        if (wr_ack) n_ack++;
        if (err) begin n_err++; err_cyc = cyc; end
        prev_req = bus_req; prev_we = bus_we; prev_addr = bus_addr; prev_busy = busy;
        bus_done = bus_req && !withhold && (cyc - rise_cyc == lat);
    endtask

    task automatic wait_falls(input int n, input int bound);
        int k = 0;
        while (n_busy_fall < n && k < bound) begin step(); k++; end
        chk("seq_complete", n_busy_fall >= n, 1);
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_ntx"}, obs_tx.size(), exp_tx.size());
        for (int i = 0; i < obs_tx.size() && i < exp_tx.size(); i++)
            chk({tag, "_tx"}, obs_tx[i], exp_tx[i]);
        chk({tag, "_ncs"}, obs_cs.size(), exp_cs.size());
        for (int i = 0; i < obs_cs.size() && i < exp_cs.size(); i++)
            chk({tag, "_cs"}, obs_cs[i], exp_cs[i]);
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, {bus_req, bus_we, bus_addr, cs, busy, wr_ack, err}, 0);
    endtask

    initial begin
        int req_cyc, k, kind;
        logic [1:0] g;
        reset = 1'b1; start_rd = 0; req_wr = 0; wr_grupo = 0;
        edit_en = 0; edit_grupo = 0; bus_done = 0;
        repeat (3) step();
        chk_quiet("reset_outputs");
        reset = 1'b0;
        step();

        // Full read, bus_done two cycles after each request.
        clear_obs(); lat = 2;
        add_read('0);
        req_cyc = cyc; start_rd = 1; step(); start_rd = 0;
        chk("rd_first_req", {bus_req, bus_we, bus_addr}, {1'b1, 1'b0, 8'h21});
        wait_falls(1, 600);
        compare_all("full_read");
        chk("full_read_len", busy_len, len_read('0, 2));
        chk("full_read_rise", busy_rise_cyc, req_cyc + 1);
        chk("full_read_ack", n_ack, 0);

        // Read while editing fecha.
        clear_obs(); edit_en = 1; edit_grupo = 2'd1; step();
        chk("hold_fecha", hold, 10'h078);
        add_read(10'h078);
        start_rd = 1; step(); start_rd = 0;
        wait_falls(1, 600);
        compare_all("edit_read");
        chk("edit_read_len", busy_len, len_read(10'h078, 2));
        edit_en = 0;

        // Write-back of timer group.
        clear_obs(); add_write(2'd2);
        req_cyc = cyc; req_wr = 1; wr_grupo = 2'd2; step(); req_wr = 0;
        wait_falls(1, 600);
        step(); step();
        compare_all("write_timer");
        chk("write_ack", n_ack, 1);
        chk("write_len", busy_len, len_write(2'd2, 2));
        chk("write_rise", busy_rise_cyc, req_cyc + 1);

        // Reads requested during a write collapse into one read after it.
        clear_obs(); add_write(2'd0); add_read('0);
        req_wr = 1; wr_grupo = 2'd0; step(); req_wr = 0;
        repeat (3) step();
        start_rd = 1; step(); start_rd = 0;
        repeat (4) step();
        start_rd = 1; step(); start_rd = 0;
        wait_falls(2, 800);
        repeat (10) step();
        compare_all("collision");
        chk("collision_ack", n_ack, 1);
        chk("collision_falls", n_busy_fall, 2);

        // Simultaneous requests: write first, then read.
        clear_obs(); add_write(2'd1); add_read('0);
        req_wr = 1; wr_grupo = 2'd1; start_rd = 1; step(); req_wr = 0; start_rd = 0;
        wait_falls(2, 800);
        compare_all("same_cycle");
        chk("same_cycle_ack", n_ack, 1);

        // Invalid group and stray bus_done cause no activity.
        clear_obs();
        req_wr = 1; wr_grupo = 2'd3; step(); req_wr = 0;
        bus_done = 1; step();
        repeat (8) step();
        chk("grp3_ntx", obs_tx.size(), 0);
        chk("grp3_ack", n_ack, 0);
        chk("grp3_busy", n_busy_fall, 0);

        // Timeout with bus_done withheld.
        clear_obs(); withhold = 1;
        start_rd = 1; step(); start_rd = 0;
        k = 0;
        while (n_err == 0 && k < 400) begin step(); k++; end
        chk("to_err_seen", n_err, 1);
        chk("to_err_time", err_cyc, first_rise + 256);
        chk("to_req_drop", {bus_req, busy}, 0);
        step();
        chk("to_err_pulse", err, 0);
        repeat (5) step();
        chk("to_ntx", obs_tx.size(), 1);
        chk("to_ncs", obs_cs.size(), 0);
        chk("to_ack", n_ack, 0);
        chk("to_idle", busy, 0);

        // Reset in WAIT with a write pending; nothing stale runs afterwards.
        start_rd = 1; step(); start_rd = 0;
        repeat (4) step();
        req_wr = 1; wr_grupo = 2'd0; step(); req_wr = 0;
        chk("pre_reset_req", bus_req, 1);
        #2 reset = 1'b1;
        #1 chk_quiet("reset_async");
        step(); step();
        reset = 1'b0; withhold = 0;
        clear_obs();
        repeat (30) step();
        chk("post_reset_ntx", obs_tx.size(), 0);
        chk("post_reset_busy", n_busy_fall, 0);

        // Randomized sequences against the transaction-level model.
        for (int it = 0; it < 10; it++) begin
            lat = $urandom_range(1, 5);
            edit_en = 1'($urandom_range(0, 1));
            edit_grupo = 2'($urandom_range(0, 3));
            step();
            clear_obs();
            kind = $urandom_range(0, 2);
            g = 2'($urandom_range(0, 3));
            req_cyc = cyc;
            if (kind == 2) begin
                add_write(g);
                req_wr = 1; wr_grupo = g; step(); req_wr = 0;
            end else begin
                add_read(model_hold(edit_en, edit_grupo));
                start_rd = 1; step(); start_rd = 0;
            end
            if (kind == 2 && g == 2'd3) begin
                repeat (8) step();
                chk("rnd_grp3_busy", n_busy_fall, 0);
            end else begin
                wait_falls(1, 600);
                chk("rnd_rise", busy_rise_cyc, req_cyc + 1);
                chk("rnd_len", busy_len, (kind == 2) ? len_write(g, lat)
                                                      : len_read(model_hold(edit_en, edit_grupo), lat));
            end
            step();
            compare_all("rnd");
            chk("rnd_ack", n_ack, (kind == 2 && g != 2'd3) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
